sm_uart_loader: RTL

Serial program loader that sits directly upstream of the instruction memory's write port. It receives a framed program image over a UART RX line, assembles little-endian 32-bit words, and issues one-cycle word writes (word address, data, write strobe) into instruction memory. While a load is in progress it holds the CPU in reset, and it releases the CPU only after a complete, error-free image has been written.

---
 rtl/sm_uart_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sm_uart_loader.sv
// Serial program loader: receives a framed UART image and writes it,
// word by word, into instruction memory while holding the CPU in reset.
module sm_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SIZE         = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        mem_wr,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [8:0]    MAXN = 9'(SIZE);
    localparam logic [7:0]    HDR  = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        WAIT_HDR,
        WAIT_LEN,
        LOAD,
        WRITE,
        FINISH
    } state_t;

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_d;
    rx_state_t     rx_st;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          byte_stb;
    logic          frm_err;

    state_t        state;
    logic [7:0]    n;
    logic [7:0]    widx;
    logic [1:0]    lane;
    logic [23:0]   word;

    // rx is asynchronous; rx_d is kept one stage behind for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_st   <= RX_START;
                        clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    // start bit still high at mid-bit means a glitch
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + ONE;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_st <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + ONE;
                    end
                end
                RX_STOP: begin
                    // back in idle by mid-stop so a back-to-back start is seen
                    if (clk_cnt == LAST) begin
                        clk_cnt  <= '0;
                        byte_stb <= rx_s2;
                        frm_err  <= !rx_s2;
                        rx_st    <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + ONE;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_HDR;
            n       <= '0;
            widx    <= '0;
            lane    <= '0;
            word    <= '0;
            mem_wr  <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            done   <= 1'b0;
            case (state)
                WAIT_HDR: begin
                    if (byte_stb && rx_byte == HDR) begin
                        state   <= WAIT_LEN;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        cpu_rst <= 1'b1;
                    end
                end
                WAIT_LEN: begin
                    if (frm_err) begin
                        state <= WAIT_HDR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_stb) begin
                        if (rx_byte != 8'd0 && {1'b0, rx_byte} <= MAXN) begin
                            state <= LOAD;
                            n     <= rx_byte;
                            widx  <= '0;
                            lane  <= '0;
                        end else begin
                            state <= WAIT_HDR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    // cpu_rst stays high on abort: memory is partly overwritten
                    if (frm_err) begin
                        state <= WAIT_HDR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_stb) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: word[7:0]   <= rx_byte;
                            2'd1: word[15:8]  <= rx_byte;
                            2'd2: word[23:16] <= rx_byte;
                            default: begin
                                mem_wr <= 1'b1;
                                mem_a  <= {24'd0, widx};
                                mem_wd <= {rx_byte, word};
                                state  <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    widx <= widx + 8'd1;
                    if (widx + 8'd1 == n) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                FINISH: state <= WAIT_HDR;
                default: state <= WAIT_HDR;
            endcase
        end
    end

endmodule
